// File: rtl/lcd_stream_timing_if.sv
// Pixel stream interface between the upstream source (frame buffer reader or
// pattern FIFO) and the panel timing stage.
//   s_valid  source -> panel  pixel beat valid
//   s_sof    source -> panel  beat is pixel (0,0) of a frame
//   s_data   source -> panel  RGB565 {R[15:11],G[10:5],B[4:0]}
//   s_ready  panel -> source  beat accepted when s_valid & s_ready
interface lcd_stream_timing_if;
    logic        s_valid;
    logic        s_sof;
    logic [15:0] s_data;
    logic        s_ready;

    modport master (output s_valid, output s_sof, output s_data, input s_ready);
    modport slave  (input s_valid, input s_sof, input s_data, output s_ready);
endinterface

// File: rtl/lcd_stream_timing.sv
// Panel-side stage of the RGB LCD path. Generates DE/HSYNC/VSYNC timing and
// pulls RGB565 pixels from a valid/ready stream, keeping the stream aligned to
// the panel frame, filling starved pixels and resynchronising when the source
// drifts.
// Ports:
//   PixelClk       pixel clock, rising edge
//   nRST           synchronous active-low reset
//   s_if           pixel stream (slave side)
//   frame_start    1-cycle pulse, registered, for h_cnt==0 && v_cnt==0
//   locked         stream aligned to panel frame
//   resync         1-cycle pulse when alignment is lost
//   underflow_cnt  saturating count of starved active pixels
//   LCD_*          registered panel pins, one cycle behind the counters
module lcd_stream_timing #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 210,
    parameter int unsigned H_SYNC   = 1,
    parameter int unsigned H_BP     = 182,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 45,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 0,
    parameter logic        SYNC_POL = 1'b0,
    parameter logic [15:0] FILL_RGB = 16'h0000
) (
    input  logic                 PixelClk,
    input  logic                 nRST,
    lcd_stream_timing_if.slave   s_if,
    output logic                 frame_start,
    output logic                 locked,
    output logic                 resync,
    output logic [15:0]          underflow_cnt,
    output logic                 LCD_DE,
    output logic                 LCD_HSYNC,
    output logic                 LCD_VSYNC,
    output logic [4:0]           LCD_R,
    output logic [5:0]           LCD_G,
    output logic [4:0]           LCD_B
);
    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HW      = $clog2(H_TOTAL + 1);
    localparam int unsigned VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYN_E = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_S = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_E = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYN_E = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_S = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_E = VW'(V_SYNC + V_BP + V_ACTIVE);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_SYNCED = 2'd2;

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [1:0]    r_state;
    logic [15:0]   r_rgb;

    logic          w_act;
    logic          w_first;
    logic          w_ready;
    logic          w_show;
    logic          w_underflow;
    logic          w_resync;
    logic [1:0]    w_next;

    assign w_act   = (r_h_cnt >= H_ACT_S) && (r_h_cnt < H_ACT_E) &&
                     (r_v_cnt >= V_ACT_S) && (r_v_cnt < V_ACT_E);
    assign w_first = (r_h_cnt == H_ACT_S) && (r_v_cnt == V_ACT_S);

    // Ready is combinational on s_sof so an unexpected sof beat is never
    // consumed; it is held upstream until the panel reaches its first pixel.
    always_comb begin
        w_ready     = 1'b0;
        w_show      = 1'b0;
        w_underflow = 1'b0;
        w_resync    = 1'b0;
        w_next      = r_state;
        case (r_state)
            ST_HUNT: begin
                w_ready = !(s_if.s_valid && s_if.s_sof);
                if (s_if.s_valid && s_if.s_sof)
                    w_next = ST_ARMED;
            end
            ST_ARMED: begin
                w_ready = w_first;
                if (w_first && s_if.s_valid && s_if.s_sof) begin
                    w_show = 1'b1;
                    w_next = ST_SYNCED;
                end
            end
            ST_SYNCED: begin
                if (w_act) begin
                    if (!s_if.s_valid) begin
                        w_ready     = 1'b1;
                        w_underflow = 1'b1;
                    end else if (s_if.s_sof == w_first) begin
                        w_ready = 1'b1;
                        w_show  = 1'b1;
                    end else if (s_if.s_sof) begin
                        w_resync = 1'b1;
                        w_next   = ST_ARMED;
                    end else begin
                        // late sof: swallow the stray beat and hunt again
                        w_ready  = 1'b1;
                        w_resync = 1'b1;
                        w_next   = ST_HUNT;
                    end
                end
            end
            default: w_next = ST_HUNT;
        endcase
    end

    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_state       <= ST_HUNT;
            r_rgb         <= '0;
            LCD_DE        <= 1'b0;
            LCD_HSYNC     <= ~SYNC_POL;
            LCD_VSYNC     <= ~SYNC_POL;
            frame_start   <= 1'b0;
            resync        <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
            end
            r_state     <= w_next;
            LCD_DE      <= w_act;
            LCD_HSYNC   <= (r_h_cnt < H_SYN_E) ? SYNC_POL : ~SYNC_POL;
            LCD_VSYNC   <= (r_v_cnt < V_SYN_E) ? SYNC_POL : ~SYNC_POL;
            frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            resync      <= w_resync;
            if (!w_act)
                r_rgb <= '0;
            else if (w_show)
                r_rgb <= s_if.s_data;
            else
                r_rgb <= FILL_RGB;
            if (w_underflow && (underflow_cnt != '1))
                underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

    assign s_if.s_ready = w_ready;
    assign locked       = (r_state == ST_SYNCED);
    assign LCD_R        = r_rgb[15:11];
    assign LCD_G        = r_rgb[10:5];
    assign LCD_B        = r_rgb[4:0];
endmodule

// File: tb/tb_lcd_stream_timing.sv
// Self-checking bench for lcd_stream_timing with small panel geometry.
// A behavioural model derives panel position from elapsed cycles since reset
// and applies the alignment rules to the driven stream; one compare process
// checks every DUT output on every cycle, and scenario checkpoints pin the
// model with hand-computed values.
module tb_lcd_stream_timing;
    localparam int HA = 8, HF = 2, HS = 1, HB = 1;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HS + HB + HA + HF;   // 12
    localparam int VT = VS + VB + VA + VF;   // 7
    localparam int FR = HT * VT;             // 84
    localparam logic [15:0] FILL = 16'h0000;

    logic        clk = 1'b0;
    logic        nrst;
    logic        frame_start, locked, resync;
    logic [15:0] underflow_cnt;
    logic        lcd_de, lcd_hs, lcd_vs;
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;

    always #5 clk = ~clk;

    lcd_stream_timing_if sif();

    lcd_stream_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .FILL_RGB(FILL)
    ) dut (
        .PixelClk(clk), .nRST(nrst), .s_if(sif),
        .frame_start(frame_start), .locked(locked), .resync(resync),
        .underflow_cnt(underflow_cnt),
        .LCD_DE(lcd_de), .LCD_HSYNC(lcd_hs), .LCD_VSYNC(lcd_vs),
        .LCD_R(lcd_r), .LCD_G(lcd_g), .LCD_B(lcd_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 hunting for sof, 1 holding sof for first pixel, 2 locked
    int          t = 0;
    int          mode = 0;
    logic        e_de, e_hs, e_vs, e_fs, e_rs;
    logic [15:0] e_rgb, e_uf;
    bit          acc = 0;

    function automatic int h_of(input int tt); return tt % HT; endfunction
    function automatic int v_of(input int tt); return (tt / HT) % VT; endfunction
    function automatic bit is_act(input int tt);
        return h_of(tt) >= HS + HB && h_of(tt) < HS + HB + HA &&
               v_of(tt) >= VS + VB && v_of(tt) < VS + VB + VA;
    endfunction
    function automatic bit is_first(input int tt);
        return h_of(tt) == HS + HB && v_of(tt) == VS + VB;
    endfunction
    function automatic bit m_ready(input int md, input int tt, input bit vld, input bit sof);
        if (md == 0) return !(vld && sof);
        if (md == 1) return is_first(tt);
        return is_act(tt) && !(vld && sof && !is_first(tt));
    endfunction

    bit m_a, m_f, m_show;
    always @(posedge clk) begin
        if (!nrst) begin
            t = 0; mode = 0; acc = 0;
            e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_rs = 0;
            e_rgb = '0; e_uf = '0;
        end else begin
            m_a    = is_act(t);
            m_f    = is_first(t);
            m_show = 0;
            acc    = sif.s_valid && m_ready(mode, t, sif.s_valid, sif.s_sof);
            e_rs   = 0;
            if (mode == 0) begin
                if (sif.s_valid && sif.s_sof) mode = 1;
            end else if (mode == 1) begin
                if (m_f && sif.s_valid && sif.s_sof) begin m_show = 1; mode = 2; end
            end else if (m_a) begin
                if (!sif.s_valid)
                    e_uf = (e_uf == 16'hFFFF) ? e_uf : e_uf + 16'd1;
                else if (sif.s_sof == m_f)
                    m_show = 1;
                else begin
                    e_rs = 1;
                    mode = sif.s_sof ? 1 : 0;
                end
            end
            e_de  = m_a;
            e_hs  = !(h_of(t) < HS);
            e_vs  = !(v_of(t) < VS);
            e_fs  = (h_of(t) == 0 && v_of(t) == 0);
            e_rgb = !m_a ? 16'h0000 : (m_show ? sif.s_data : FILL);
            t++;
        end
    end

    // ---------------- compare process ----------------
    bit chk_on = 0;
    int c_hs = 0, c_vs = 0, c_de = 0, c_fs = 0, c_rs = 0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("s_ready", 32'(sif.s_ready), 32'(m_ready(mode, t, sif.s_valid, sif.s_sof)));
            chk("locked", 32'(locked), 32'(mode == 2));
            chk("LCD_DE", 32'(lcd_de), 32'(e_de));
            chk("LCD_HSYNC", 32'(lcd_hs), 32'(e_hs));
            chk("LCD_VSYNC", 32'(lcd_vs), 32'(e_vs));
            chk("frame_start", 32'(frame_start), 32'(e_fs));
            chk("resync", 32'(resync), 32'(e_rs));
            chk("rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'(e_rgb));
            chk("underflow_cnt", 32'(underflow_cnt), 32'(e_uf));
            if (!lcd_hs) c_hs++;
            if (!lcd_vs) c_vs++;
            if (lcd_de) c_de++;
            if (frame_start) c_fs++;
            if (resync) c_rs++;
        end
    end

    // ---------------- source / stimulus ----------------
    bit src_en = 0;
    int src_pos = 0, src_frm = 1, src_len = 32, next_len = 32;
    int p_gap = 0, force_gap = 0;
    bit gap_req = 0;

    task automatic step();
        @(posedge clk); #2;
        if (acc) begin
            src_pos++;
            if (src_pos >= src_len) begin
                src_pos = 0; src_frm++; src_len = next_len; next_len = 32;
            end
        end
        if (gap_req && mode == 2 && h_of(t) == 4 && v_of(t) == 3) begin
            force_gap = 3; gap_req = 0;
        end
        if (force_gap > 0) begin
            sif.s_valid = 1'b0; force_gap--;
        end else begin
            sif.s_valid = src_en && ($urandom_range(99) >= p_gap);
        end
        sif.s_sof  = (src_pos == 0);
        sif.s_data = {src_frm[7:0], 3'(src_pos / 8), 5'(src_pos % 8)};
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int s_hs, s_vs, s_de, s_fs, s_rs, guard;
    initial begin
        nrst = 1'b0;
        sif.s_valid = 1'b0; sif.s_sof = 1'b0; sif.s_data = '0;
        @(posedge clk); #2; chk_on = 1;
        run(2);
        nrst = 1'b1;

        // free-run with no source: one frame of pin statistics
        run(FR);
        s_hs = c_hs; s_vs = c_vs; s_de = c_de; s_fs = c_fs;
        run(FR);
        chk("hsync_low_per_frame", 32'(c_hs - s_hs), 32'd7);
        chk("vsync_low_per_frame", 32'(c_vs - s_vs), 32'd12);
        chk("de_per_frame", 32'(c_de - s_de), 32'd32);
        chk("frame_start_per_frame", 32'(c_fs - s_fs), 32'd1);
        chk("idle_locked", 32'(locked), 32'd0);

        // aligned source
        src_en = 1; src_pos = 0;
        run(3 * FR);
        chk("aligned_locked", 32'(locked), 32'd1);
        chk("aligned_underflow", 32'(underflow_cnt), 32'd0);

        // three starved pixels while locked
        gap_req = 1; guard = 0;
        while (gap_req && guard < 3 * FR) begin step(); guard++; end
        if (gap_req) chk("gap_timeout", 32'd1, 32'd0);
        run(5 * FR);
        chk("gap_underflow", 32'(underflow_cnt), 32'd3);
        chk("gap_relocked", 32'(locked), 32'd1);

        // one 31-pixel source frame
        s_rs = c_rs; next_len = 31;
        run(4 * FR);
        chk("short_frame_resyncs", 32'(c_rs - s_rs), 32'd1);
        chk("short_frame_relocked", 32'(locked), 32'd1);
        chk("short_frame_underflow", 32'(underflow_cnt), 32'd3);

        // reset pulse in the middle of an active line
        guard = 0;
        while (!(mode == 2 && h_of(t) == 5 && v_of(t) == 3) && guard < 3 * FR) begin step(); guard++; end
        if (guard >= 3 * FR) chk("reset_wait_timeout", 32'd1, 32'd0);
        nrst = 1'b0;
        step();
        nrst = 1'b1; src_en = 0;
        @(negedge clk);
        chk("rst_de", 32'(lcd_de), 32'd0);
        chk("rst_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_underflow", 32'(underflow_cnt), 32'd0);

        // source starts mid-frame without sof
        run(20);
        src_pos = 13; src_frm = 100; src_len = 32; src_en = 1;
        run(3 * FR);
        chk("midstart_locked", 32'(locked), 32'd1);
        chk("midstart_underflow", 32'(underflow_cnt), 32'd0);

        // randomized gaps and frame lengths
        p_gap = 8;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(3) == 0) next_len = $urandom_range(33, 31);
            run(FR);
        end
        p_gap = 0;
        run(3 * FR);

        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
